// File: rtl/mp_arith_pkg.sv
// mp_arith_pkg: shared FSM state encoding and command constants for the modular adder.
package mp_arith_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    FINAL = 2'd3
  } stateT;
  localparam logic CMD_ADD = 1'b0;
  localparam logic CMD_SUB = 1'b1;
endpackage

// File: rtl/carry_select_adder_Nb.sv
// carry_select_adder_Nb: WIDTH-bit adder, upper half precomputed for both carries and selected by the lower carry.
module carry_select_adder_Nb #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCin,
  output logic [WIDTH-1:0] oSum,
  output logic             oCout
);
  localparam int LO = WIDTH / 2;
  localparam int HI = WIDTH - LO;
  if (LO == 0) begin : gRipple
    assign {oCout, oSum} = {1'b0, iA} + {1'b0, iB} + {{WIDTH{1'b0}}, iCin};
  end else begin : gSelect
    logic [LO:0] lo;
    logic [HI:0] hi0, hi1;
    assign lo  = {1'b0, iA[LO-1:0]} + {1'b0, iB[LO-1:0]} + {{LO{1'b0}}, iCin};
    assign hi0 = {1'b0, iA[WIDTH-1:LO]} + {1'b0, iB[WIDTH-1:LO]};
    assign hi1 = {1'b0, iA[WIDTH-1:LO]} + {1'b0, iB[WIDTH-1:LO]} + {{HI{1'b0}}, 1'b1};
    assign {oCout, oSum} = lo[LO] ? {hi1, lo[LO-1:0]} : {hi0, lo[LO-1:0]};
  end
endmodule

// File: rtl/mp_mod_adder.sv
// mp_mod_adder: word-serial (A+B) mod M / (A-B) mod M; pass 1 forms A+/-B, pass 2 forms the
// M-corrected candidate, FINAL picks whichever is fully reduced.
module mp_mod_adder
  import mp_arith_pkg::*;
#(
  parameter int OPERAND_WIDTH = 1024,
  parameter int ADDER_WIDTH   = 64
) (
  input  logic                     iClk,
  input  logic                     iRstn,
  input  logic                     iStart,
  input  logic                     iCommand,
  input  logic [OPERAND_WIDTH-1:0] iOpA,
  input  logic [OPERAND_WIDTH-1:0] iOpB,
  input  logic [OPERAND_WIDTH-1:0] iModulus,
  output logic [OPERAND_WIDTH-1:0] oRes,
  output logic                     oBusy,
  output logic                     oDone
);
  localparam int OW      = OPERAND_WIDTH;
  localparam int AW      = ADDER_WIDTH;
  localparam int N_WORDS = OW / AW;
  localparam int CW      = $clog2(N_WORDS) + 1;
  if (OW % AW != 0) begin : gBadWidth
    $error("mp_mod_adder: OPERAND_WIDTH must be a multiple of ADDER_WIDTH");
  end
  stateT state, nextState;
  logic [OW-1:0] regA, regB, regM, regT, regU;
  logic [CW-1:0] cnt;
  logic          cmd, carry, c1, c2;
  logic [AW-1:0] addA, addB, sum;
  logic          addCin, cout, lastWord, selU;
  assign lastWord = cnt == CW'(N_WORDS - 1);
  assign oBusy    = state != IDLE;
  assign selU     = cmd == CMD_ADD ? (c1 | c2) : ~c1;
  always_comb begin
    nextState = state == IDLE  ? (iStart ? PASS1 : IDLE) :
                state == PASS1 ? (lastWord ? PASS2 : PASS1) :
                state == PASS2 ? (lastWord ? FINAL : PASS2) : IDLE;
    addA   = state == PASS2 ? regT[AW-1:0] : regA[AW-1:0];
    addB   = state == PASS2 ? regM[AW-1:0] : regB[AW-1:0];
    addCin = cnt == '0 ? (state == PASS2 ? ~cmd : cmd) : carry;
  end
  carry_select_adder_Nb #(.WIDTH(AW)) uAdder (
    .iA   (addA),
    .iB   (addB),
    .iCin (addCin),
    .oSum (sum),
    .oCout(cout)
  );
  always_ff @(posedge iClk or negedge iRstn)
    if (!iRstn) state <= IDLE;
    else        state <= nextState;
  // Operands are pre-conditioned at capture so both passes are plain additions.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      regA  <= '0;
      regB  <= '0;
      regM  <= '0;
      regT  <= '0;
      regU  <= '0;
      cnt   <= '0;
      cmd   <= 1'b0;
      carry <= 1'b0;
      c1    <= 1'b0;
      c2    <= 1'b0;
      oRes  <= '0;
      oDone <= 1'b0;
    end else if (state == IDLE) begin
      oDone <= 1'b0;
      if (iStart) begin
        regA <= iOpA;
        regB <= iCommand == CMD_SUB ? ~iOpB : iOpB;
        regM <= iCommand == CMD_ADD ? ~iModulus : iModulus;
        cmd  <= iCommand;
        cnt  <= '0;
      end
    end else if (state == FINAL) begin
      oRes  <= selU ? regU : regT;
      oDone <= 1'b1;
    end else begin
      carry <= cout;
      cnt   <= lastWord ? '0 : cnt + CW'(1);
      if (state == PASS1) begin
        regA <= regA >> AW;
        regB <= regB >> AW;
        regT <= (regT >> AW) | (OW'(sum) << (OW - AW));
        if (lastWord) c1 <= cout;
      end else begin
        regT <= (regT >> AW) | (regT << (OW - AW));
        regM <= regM >> AW;
        regU <= (regU >> AW) | (OW'(sum) << (OW - AW));
        if (lastWord) c2 <= cout;
      end
    end
  end
endmodule
